// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - writeback trace capture into a circular buffer with FWFT drain
module wb_trace_buffer #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 16,
  parameter int CYCLE_W    = 16,
  parameter int DROP_W     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     stop_when_full,
  input  logic                     wb_write_enable,
  input  logic [REG_ADDR_W-1:0]    wb_write_address,
  input  logic [XLEN-1:0]          wb_write_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CYCLE_W-1:0]       out_cycle,
  output logic [REG_ADDR_W-1:0]    out_address,
  output logic [XLEN-1:0]          out_value,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DROP_W-1:0]        dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Entry storage: plain registers, never reset; validity is tracked by count.
  logic [CYCLE_W-1:0]    mem_cycle   [DEPTH];
  logic [REG_ADDR_W-1:0] mem_address [DEPTH];
  logic [XLEN-1:0]       mem_value   [DEPTH];

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CYCLE_W-1:0] cycle_ctr;

  logic capture;
  logic full;
  logic pop;
  logic do_write;
  logic overwrite;
  logic discard;
  logic drop_event;
  logic advance_rd;

  // Event classification for this edge; x0 writes are invisible to capture and drop logic.
  always_comb begin
    capture    = enable && wb_write_enable && (wb_write_address != '0);
    full       = (count == FULL_COUNT);
    pop        = out_valid && out_ready;
    // A pop frees the head slot, so a full buffer with a simultaneous pop still accepts the push.
    do_write   = capture && (!full || pop || !stop_when_full);
    overwrite  = capture && full && !pop && !stop_when_full;
    discard    = capture && full && !pop && stop_when_full;
    drop_event = overwrite || discard;
    // Overwriting the oldest entry moves the head forward exactly like a pop would.
    advance_rd = pop || overwrite;
  end

  // Free-running cycle stamp; clear restarts it so stamps are relative to the flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_ctr <= '0;
    end else if (clear) begin
      cycle_ctr <= '0;
    end else begin
      cycle_ctr <= cycle_ctr + CYCLE_W'(1);
    end
  end

  // Write side: store the record at the write pointer (stamp is the pre-increment counter).
  always_ff @(posedge clock) begin
    if (do_write && !clear) begin
      mem_cycle[wr_ptr]   <= cycle_ctr;
      mem_address[wr_ptr] <= wb_write_address;
      mem_value[wr_ptr]   <= wb_write_value;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (advance_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // Overwrite keeps count at DEPTH; push+pop keeps it unchanged.
      if (do_write && !pop && !full) begin
        count <= count + CNT_W'(1);
      end else if (pop && !do_write) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Saturating count of events that were discarded or displaced an older record.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dropped <= '0;
    end else if (clear) begin
      dropped <= '0;
    end else if (drop_event && (dropped != {DROP_W{1'b1}})) begin
      dropped <= dropped + DROP_W'(1);
    end
  end

  // First-word-fall-through view of the head; outputs read as zero when empty.
  always_comb begin
    out_valid   = (count != '0);
    out_cycle   = '0;
    out_address = '0;
    out_value   = '0;
    if (out_valid) begin
      out_cycle   = mem_cycle[rd_ptr];
      out_address = mem_address[rd_ptr];
      out_value   = mem_value[rd_ptr];
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - scoreboard bench for wb_trace_buffer
module tb_wb_trace_buffer;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [15:0] c;
    logic [4:0]  a;
    logic [31:0] v;
  } ent_t;

  logic        clock;
  logic        reset;
  logic        en;
  logic        clr;
  logic        swf;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wv;
  logic        out_valid;
  logic        rdy;
  logic [15:0] out_cycle;
  logic [4:0]  out_address;
  logic [31:0] out_value;
  logic [4:0]  count;
  logic [15:0] dropped;

  ent_t        q[$];
  logic [15:0] cyc;
  logic [15:0] exp_drop;
  int          errors;
  int          checks;

  wb_trace_buffer #(
    .XLEN(32), .REG_ADDR_W(5), .DEPTH(DEPTH), .CYCLE_W(16), .DROP_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(en),
    .clear(clr),
    .stop_when_full(swf),
    .wb_write_enable(we),
    .wb_write_address(wa),
    .wb_write_value(wv),
    .out_valid(out_valid),
    .out_ready(rdy),
    .out_cycle(out_cycle),
    .out_address(out_address),
    .out_value(out_value),
    .count(count),
    .dropped(dropped)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_state();
    check("valid", 64'(out_valid), 64'(q.size() != 0));
    check("count", 64'(count), 64'(q.size()));
    check("dropped", 64'(dropped), 64'(exp_drop));
    if (q.size() != 0) begin
      check("head_cycle", 64'(out_cycle), 64'(q[0].c));
      check("head_addr", 64'(out_address), 64'(q[0].a));
      check("head_value", 64'(out_value), 64'(q[0].v));
    end else begin
      check("idle_out", {11'd0, out_cycle, out_address, out_value}, 64'd0);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_drop = '0;
    cyc = '0;
  endtask

  // Inputs are stable from one negedge to the next; model the coming posedge.
  task automatic model_edge();
    bit cap;
    bit pop;
    ent_t e;
    cap = en && we && (wa != 5'd0);
    pop = (q.size() != 0) && rdy;
    e = '{c: cyc, a: wa, v: wv};
    if (clr) begin
      model_reset();
    end else begin
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (q.size() == DEPTH) begin
          if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
          if (!swf) begin
            void'(q.pop_front());
            q.push_back(e);
          end
        end else begin
          q.push_back(e);
        end
      end
      cyc = cyc + 16'd1;
    end
  endtask

  task automatic step(input bit chk);
    if (chk) compare_state();
    model_edge();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    we = 1'b1;
    wa = a;
    wv = v;
    step(1'b1);
    we = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    en = 1'b1;
    clr = 1'b0;
    swf = 1'b1;
    we = 1'b0;
    wa = '0;
    wv = '0;
    rdy = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_dropped", 64'(dropped), 64'd0);
    reset = 1'b1;

    // Two writes after three idle cycles, then drain one at a time.
    repeat (3) step(1'b1);
    wr(5'd10, 32'd5);
    wr(5'd11, 32'd7);
    check("t1_count", 64'(count), 64'd2);
    check("t1_head", {out_cycle, out_address, out_value}, {16'd3, 5'd10, 32'd5});
    rdy = 1'b1;
    step(1'b1);
    rdy = 1'b0;
    check("t1_head2", {out_cycle, out_address, out_value}, {16'd4, 5'd11, 32'd7});
    rdy = 1'b1;
    step(1'b1);
    rdy = 1'b0;
    check("t1_empty", {out_valid, count}, 6'd0);

    // x0 and disabled writes are ignored.
    wr(5'd0, 32'd99);
    en = 1'b0;
    wr(5'd12, 32'd1);
    en = 1'b1;
    step(1'b1);
    check("t2_count", 64'(count), 64'd0);
    check("t2_dropped", 64'(dropped), 64'd0);

    // Stop-when-full: keeps x1..x16.
    swf = 1'b1;
    for (int i = 1; i <= 20; i++) wr(5'(i), 32'h1000 + 32'(i));
    check("t3_count", 64'(count), 64'd16);
    check("t3_dropped", 64'(dropped), 64'd4);
    check("t3_head", 64'(out_address), 64'd1);
    rdy = 1'b1;
    repeat (16) step(1'b1);
    rdy = 1'b0;
    check("t3_drained", 64'(count), 64'd0);
    clr = 1'b1;
    step(1'b1);
    clr = 1'b0;

    // Overwrite mode: keeps x5..x20, then push+pop while full.
    swf = 1'b0;
    for (int i = 1; i <= 20; i++) wr(5'(i), 32'h2000 + 32'(i));
    check("t4_count", 64'(count), 64'd16);
    check("t4_dropped", 64'(dropped), 64'd4);
    check("t4_head", 64'(out_address), 64'd5);
    rdy = 1'b1;
    wr(5'd21, 32'h2015);
    check("t4_pp_count", 64'(count), 64'd16);
    check("t4_pp_dropped", 64'(dropped), 64'd4);
    check("t4_pp_head", 64'(out_address), 64'd6);
    repeat (16) step(1'b1);
    rdy = 1'b0;
    check("t4_drained", 64'(count), 64'd0);

    // Clear together with a write: nothing recorded.
    wr(5'd7, 32'h77);
    clr = 1'b1;
    wr(5'd8, 32'h88);
    clr = 1'b0;
    check("t5_clr_count", 64'(count), 64'd0);
    check("t5_clr_dropped", 64'(dropped), 64'd0);

    // Cycle stamp wrap: 2^16+1 idle cycles after the clear, then a write.
    repeat (65537) step(1'b0);
    wr(5'd5, 32'h55);
    check("t5_wrap_stamp", 64'(out_cycle), 64'd1);
    rdy = 1'b1;
    step(1'b1);
    rdy = 1'b0;

    // Async reset mid-drain with six entries held and some drops.
    swf = 1'b1;
    for (int i = 1; i <= 18; i++) wr(5'(i), 32'h3000 + 32'(i));
    rdy = 1'b1;
    repeat (10) step(1'b1);
    check("t6_count", 64'(count), 64'd6);
    check("t6_dropped", 64'(dropped), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_count", 64'(count), 64'd0);
    check("t6_rst_dropped", 64'(dropped), 64'd0);
    check("t6_rst_out", {out_cycle, out_address, out_value}, 53'd0);
    model_reset();
    rdy = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    wr(5'd9, 32'h99);
    check("t6_resume", {count, out_cycle, out_address, out_value}, {5'd1, 16'd0, 5'd9, 32'h99});
    step(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
Synthesizable writeback trace capture for the pipelined CPU. It snoops the register-bank write port and records every architectural register write as {cycle stamp, register address, value}. Records go into a parametrised circular buffer, drained through a valid/ready port. It replaces per-cycle register dumps and can sit inside the CPU for on-board debug (LED/UART drain) or simulation.

Parameters:
XLEN, 32, register data width
REG_ADDR_W, 5, register address width
DEPTH, 16, buffer entries; power of two, >= 2
CYCLE_W, 16, cycle-stamp width
DROP_W, 16, dropped-event counter width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  capture enable; drain still works when low
clear  in  1  synchronous flush
stop_when_full  in  1  1 = discard new events when full; 0 = overwrite oldest
wb_write_enable  in  1  register-bank write strobe
wb_write_address  in  REG_ADDR_W  destination register
wb_write_value  in  XLEN  written value
out_valid  out  1  oldest entry available
out_ready  in  1  consumer accepts entry
out_cycle  out  CYCLE_W  cycle stamp of oldest entry
out_address  out  REG_ADDR_W  register of oldest entry
out_value  out  XLEN  value of oldest entry
count  out  $clog2(DEPTH)+1  entries held
dropped  out  DROP_W  events lost or overwritten, saturating

Behaviour:
- Reset (reset=0, asynchronous, any time, including mid-drain): wr/rd pointers, count, dropped, cycle counter = 0; out_valid=0; out_cycle/out_address/out_value = 0. Entry storage needs no reset.
- Cycle counter: free-running; increments every clock edge regardless of enable; wraps 2^CYCLE_W-1 -> 0.
- Capture condition on each edge: enable && wb_write_enable && wb_write_address != 0. Writes to x0 are never recorded and never counted as dropped.
- Captured stamp = cycle counter value before the edge's increment.
- Pop condition: out_valid && out_ready. Pop with empty buffer: no effect.
- Output is first-word-fall-through from registered storage:
  - out_valid = (count != 0).
  - out_* show the entry at the read pointer.
  - An event captured at edge N is visible on out_* after edge N, if the buffer was empty.
  - When out_valid=0, out_* hold 0.
- Push, not full: write entry at wr ptr, wr ptr+1 (mod DEPTH), count+1.
- Push and pop together, any fill level including full: both occur; count unchanged; no drop.
- Push when full, no pop, stop_when_full=1: entry discarded; dropped+1.
- Push when full, no pop, stop_when_full=0: oldest overwritten; wr and rd ptr both advance; count stays DEPTH; dropped+1.
- dropped saturates at 2^DROP_W-1.
- clear=1 at an edge:
  - count, pointers, dropped and cycle counter go to 0.
  - Has priority over a simultaneous push and pop; that cycle's event is not recorded.
- Pointers wrap mod DEPTH. count ranges 0..DEPTH. Full = (count == DEPTH).
- out_* remain stable while out_valid=1 and out_ready=0, except in overwrite mode when full and a new push displaces the head.

Test Plan:
- Reset, then writes x10=5 @cycle 3 and x11=7 @cycle 4 with out_ready=0 -> count=2; head shows {3,10,5}; pulse ready -> head {4,11,7}; pulse again -> out_valid=0, count=0.
- Write to x0 value 99 with enable=1, then x12=1 with enable=0 -> count=0, dropped=0.
- DEPTH=16, stop_when_full=1, 20 writes x1..x20 with no drain -> count=16, dropped=4; drain yields x1..x16 in order.
- Same stimulus with stop_when_full=0 -> count=16, dropped=4; drain yields x5..x20. Also assert push+pop while full -> count stays 16, dropped unchanged.
- Run 2^16+2 cycles, writing x5 at the last cycle -> stamp = 1 (wrap). Assert clear together with a write -> count=0, dropped=0, write not recorded.
- Assert reset low asynchronously mid-drain with count=6 -> out_valid, count, dropped = 0 immediately, before the next clock edge; capture resumes after reset releases.
